// File: rtl/mod_n_counter_pkg.sv
// Shared constants and helpers for the modulo-N counter family.
// Optional saturating build: define MOD_N_COUNTER_SAT_EN.
package mod_n_counter_pkg;

    // Direction encoding for the Up pin
    localparam logic CNT_UP   = 1'b1;
    localparam logic CNT_DOWN = 1'b0;

    // What the count register does on the next edge, in priority order
    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_STEP = 2'd1,
        OP_LOAD = 2'd2,
        OP_CLR  = 2'd3
    } cnt_op_e;

    // Bits needed to hold 0..n-1 (minimum 1), so instantiators can size WIDTH
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    // Clear beats load beats an enabled step; everything else holds
    function automatic cnt_op_e sel_op(input logic clr, input logic load, input logic step);
        if (clr)       return OP_CLR;
        else if (load) return OP_LOAD;
        else if (step) return OP_STEP;
        else           return OP_HOLD;
    endfunction

endpackage

// File: rtl/mod_n_next.sv
// Combinational next-state and terminal-count logic for mod_n_counter.
// Wraps at the rails by default; with MOD_N_COUNTER_SAT_EN defined it
// holds at MODULUS-1 going up and at 0 going down.
module mod_n_next
    import mod_n_counter_pkg::*;
#(
    parameter int MODULUS = 10,
    parameter int WIDTH   = 4
) (
    input  logic [WIDTH-1:0] q,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] nxt,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MODV = (WIDTH + 1)'(MODULUS);

    logic             at_max;
    logic             at_min;
    logic             d_ok;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] step_up;
    logic [WIDTH-1:0] step_dn;

    // Rail detection and terminal count for the current direction
    always_comb begin
        at_max = (q == MAXV);
        at_min = (q == '0);
        tc     = (up == CNT_UP) ? at_max : at_min;
    end

    // Load value is clamped so Q can never leave 0..MODULUS-1
    always_comb begin
        d_ok     = ({1'b0, d} < MODV);
        load_val = d_ok ? d : MAXV;
    end

    // One step in each direction; the rail behaviour is the only difference between builds
    always_comb begin
`ifdef MOD_N_COUNTER_SAT_EN
        step_up = at_max ? q  : q + WIDTH'(1);
        step_dn = at_min ? q  : q - WIDTH'(1);
`else
        // With MODULUS == 2^WIDTH the explicit wrap matches natural overflow
        step_up = at_max ? '0   : q + WIDTH'(1);
        step_dn = at_min ? MAXV : q - WIDTH'(1);
`endif
    end

    // Load takes precedence over a step; the caller decides whether either applies
    always_comb begin
        if (load)              nxt = load_val;
        else if (up == CNT_UP) nxt = step_up;
        else                   nxt = step_dn;
    end

endmodule

// File: rtl/mod_n_counter.sv
// Synchronous cascadable modulo-N counter: count register, priority mux and carry-out.
// Optional saturating build: define MOD_N_COUNTER_SAT_EN (handled in mod_n_next).
module mod_n_counter
    import mod_n_counter_pkg::*;
#(
    parameter int MODULUS   = 10,
    parameter int WIDTH     = 4,
    parameter int RESET_VAL = 0
) (
    input  logic             Clk,
    input  logic             Clr,
    input  logic             En,
    input  logic             Ci,
    input  logic             Up,
    input  logic             Load,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             Tc,
    output logic             Co
);

    // Reject configurations whose count range does not fit or whose reset value is out of range
    if (MODULUS < 2 || MODULUS > 2 ** WIDTH) begin : g_bad_modulus
        $error("mod_n_counter: MODULUS must be in 2..2**WIDTH");
    end
    if (RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_reset
        $error("mod_n_counter: RESET_VAL must be in 0..MODULUS-1");
    end

    localparam logic [WIDTH-1:0] RST = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] nxt;
    logic             step;
    cnt_op_e          op;

    mod_n_next #(
        .MODULUS (MODULUS),
        .WIDTH   (WIDTH)
    ) u_next (
        .q    (Q),
        .up   (Up),
        .load (Load),
        .d    (D),
        .nxt  (nxt),
        .tc   (Tc)
    );

    // Carry-out looks at the pre-edge Q, so a load that coincides with a wrap still carries
    always_comb begin
        step = En & Ci;
        Co   = Tc & step;
        op   = sel_op(Clr, Load, step);
    end

    // Count register with clear > load > step > hold priority
    always_ff @(posedge Clk) begin
        case (op)
            OP_CLR:  Q <= RST;
            OP_LOAD: Q <= nxt;
            OP_STEP: Q <= nxt;
            default: Q <= Q;
        endcase
    end

endmodule

// File: tb/tb_mod_n_counter.sv
// Self-checking bench for mod_n_counter: directed vector table, a two-digit
// cascade, a RESET_VAL sequence and randomized stimulus against a reference model.
// Expectations follow MOD_N_COUNTER_SAT_EN when it is defined.
module tb_mod_n_counter;

`ifdef MOD_N_COUNTER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // main decade counter
    logic       clr, load, en, ci, up;
    logic [3:0] d, q;
    logic       tc, co;

    // two-digit cascade
    logic       c_clr, c_en, c_up;
    logic [3:0] c_d;
    logic       c_load;
    logic [3:0] u_q, t_q;
    logic       u_tc, u_co, t_tc, t_co;

    // random-stimulus instances
    logic       r_clr, r_load, r_en, r_ci, r_up;
    logic [3:0] r_d;
    logic [3:0] a_q, b_q;
    logic       a_tc, a_co, b_tc, b_co;

    mod_n_counter #(.MODULUS(10), .WIDTH(4), .RESET_VAL(0)) dut (
        .Clk(clk), .Clr(clr), .En(en), .Ci(ci), .Up(up), .Load(load), .D(d),
        .Q(q), .Tc(tc), .Co(co));

    mod_n_counter #(.MODULUS(10), .WIDTH(4), .RESET_VAL(0)) u_units (
        .Clk(clk), .Clr(c_clr), .En(c_en), .Ci(1'b1), .Up(c_up), .Load(c_load), .D(c_d),
        .Q(u_q), .Tc(u_tc), .Co(u_co));

    mod_n_counter #(.MODULUS(10), .WIDTH(4), .RESET_VAL(0)) u_tens (
        .Clk(clk), .Clr(c_clr), .En(c_en), .Ci(u_co), .Up(c_up), .Load(c_load), .D(c_d),
        .Q(t_q), .Tc(t_tc), .Co(t_co));

    mod_n_counter #(.MODULUS(16), .WIDTH(4), .RESET_VAL(0)) u_a (
        .Clk(clk), .Clr(r_clr), .En(r_en), .Ci(r_ci), .Up(r_up), .Load(r_load), .D(r_d),
        .Q(a_q), .Tc(a_tc), .Co(a_co));

    mod_n_counter #(.MODULUS(10), .WIDTH(4), .RESET_VAL(3)) u_b (
        .Clk(clk), .Clr(r_clr), .En(r_en), .Ci(r_ci), .Up(r_up), .Load(r_load), .D(r_d),
        .Q(b_q), .Tc(b_tc), .Co(b_co));

    typedef struct {
        logic       clr, load, en, ci, up;
        logic [3:0] d;
        logic [3:0] eq;
        logic       etc, eco;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic c, input logic l, input logic e, input logic cc,
                       input logic u, input int dd, input int eq, input logic etc,
                       input logic eco);
        vec_t v;
        v.clr = c; v.load = l; v.en = e; v.ci = cc; v.up = u;
        v.d = 4'(dd); v.eq = 4'(eq); v.etc = etc; v.eco = eco;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
        end
    endtask

    // Reference: modular arithmetic straight from the counting rules
    function automatic int ref_next(input int cq, input bit c, input bit l, input int dd,
                                    input bit e, input bit cc, input bit u,
                                    input int m, input int rv);
        if (c) return rv;
        if (l) return (dd < m) ? dd : m - 1;
        if (!(e && cc)) return cq;
        if (SAT) return u ? ((cq + 1 > m - 1) ? m - 1 : cq + 1) : ((cq - 1 < 0) ? 0 : cq - 1);
        return u ? (cq + 1) % m : (cq - 1 + m) % m;
    endfunction

    function automatic bit ref_tc(input int cq, input bit u, input int m);
        return u ? (cq == m - 1) : (cq == 0);
    endfunction

    int exp_c, ma, mb, na, nb;

    initial begin
        // ---------------- directed vector table ----------------
        // up count through the wrap
        for (int i = 0; i < 9; i++) add(0,0,1,1,1,0, i+1, 0,0);
        if (!SAT) begin
            add(0,0,1,1,1,0, 0, 1,1);
            add(0,0,1,1,1,0, 1, 0,0);
            add(0,0,1,1,1,0, 2, 0,0);
            add(1,0,0,1,1,0, 0, 0,0);
            add(0,0,1,1,0,0, 9, 1,1);
        end else begin
            add(0,0,1,1,1,0, 9, 1,1);
            add(0,0,1,1,1,0, 9, 1,1);
            add(0,0,1,1,1,0, 9, 1,1);
            add(1,0,0,1,1,0, 0, 1,0);
            add(0,0,1,1,0,0, 0, 1,1);
            add(0,1,0,0,0,9, 9, 1,0);
        end
        // down count, then direction flip at 5
        add(0,0,1,1,0,0, 8, 0,0);
        add(0,0,1,1,0,0, 7, 0,0);
        add(0,0,1,1,0,0, 6, 0,0);
        add(0,0,1,1,0,0, 5, 0,0);
        add(0,0,1,1,1,0, 6, 0,0);
        add(0,0,0,1,1,0, 6, 0,0);   // En=0 holds
        add(0,0,1,0,0,0, 6, 0,0);   // Ci=0 holds
        // loads, clamping, load/clear priority
        add(0,1,0,0,1,7,  7, 0,0);
        add(0,1,0,0,1,13, 9, 0,0);
        add(0,0,0,1,1,0,  9, 1,0);
        add(0,0,0,1,0,0,  9, 0,0);
        add(1,1,1,1,1,5,  0, 1,1);
        add(0,1,0,1,1,15, 9, 0,0);
        add(0,1,1,1,1,3,  3, 1,1);  // load wins, Co from pre-load Q
        add(0,1,0,0,1,10, 9, 0,0);
        add(0,1,1,1,1,0,  0, 1,1);
        add(0,0,1,0,0,0,  0, 1,0);
        // clear mid-count
        add(0,1,0,0,1,6,  6, 0,0);
        add(1,0,1,1,1,0,  0, 0,0);
        // up from 8 through the top rail
        add(0,1,0,0,1,8,  8, 0,0);
        add(0,0,1,1,1,0,  9, 0,0);
        add(0,0,1,1,1,0,  SAT ? 9 : 0, 1,1);
        add(0,0,1,1,1,0,  SAT ? 9 : 1, SAT ? 1 : 0, SAT ? 1 : 0);
        add(0,0,1,1,1,0,  SAT ? 9 : 2, SAT ? 1 : 0, SAT ? 1 : 0);
        // down at the bottom rail
        add(1,0,0,1,1,0,  0, SAT ? 1 : 0, 0);
        add(0,0,1,1,0,0,  SAT ? 0 : 9, 1,1);

        // ---------------- reset ----------------
        clr = 1; load = 0; en = 0; ci = 1; up = 1; d = 0;
        c_clr = 1; c_en = 0; c_up = 1; c_load = 0; c_d = 0;
        r_clr = 1; r_load = 0; r_en = 0; r_ci = 1; r_up = 1; r_d = 0;
        @(posedge clk); #1;
        chk("reset_q", 32'(q), 0);
        chk("reset_tc", 32'(tc), 0);
        chk("reset_co", 32'(co), 0);
        chk("reset_rv3", 32'(b_q), 3);
        chk("reset_casc", 32'({t_q, u_q}), 0);
        clr = 0; c_clr = 0; r_clr = 0;

        // ---------------- table ----------------
        foreach (tbl[i]) begin
            clr = tbl[i].clr; load = tbl[i].load; en = tbl[i].en;
            ci = tbl[i].ci; up = tbl[i].up; d = tbl[i].d;
            #1;
            chk($sformatf("vec%0d_tc", i), 32'(tc), 32'(tbl[i].etc));
            chk($sformatf("vec%0d_co", i), 32'(co), 32'(tbl[i].eco));
            @(posedge clk); #1;
            chk($sformatf("vec%0d_q", i), 32'(q), 32'(tbl[i].eq));
        end
        clr = 0; load = 0; en = 0;

        // ---------------- cascade 00..99 ----------------
        exp_c = 0;
        c_en = 1; c_up = 1;
        for (int i = 0; i < 100; i++) begin
            if (i == 50) begin
                c_en = 0;
                for (int k = 0; k < 3; k++) begin
                    @(posedge clk); #1;
                    chk("casc_hold", 32'(t_q) * 10 + 32'(u_q), 32'(exp_c));
                end
                c_en = 1;
            end
            #1;
            chk("casc_uco", 32'(u_co), 32'((exp_c % 10) == 9));
            @(posedge clk); #1;
            exp_c = SAT ? ((exp_c + 1 > 99) ? 99 : exp_c + 1) : (exp_c + 1) % 100;
            chk("casc_q", 32'(t_q) * 10 + 32'(u_q), 32'(exp_c));
        end
        chk("casc_end", 32'(t_q) * 10 + 32'(u_q), SAT ? 99 : 0);
        c_en = 0;

        // ---------------- RESET_VAL=3 clear mid-count ----------------
        r_load = 1; r_d = 6;
        @(posedge clk); #1;
        chk("rv3_load", 32'(b_q), 6);
        r_load = 0; r_clr = 1; r_en = 1; r_ci = 1; r_up = 1;
        @(posedge clk); #1;
        chk("rv3_clr", 32'(b_q), 3);
        chk("rv3_a_clr", 32'(a_q), 0);
        r_clr = 0;
        ma = 0; mb = 3;

        // ---------------- randomized vs reference ----------------
        for (int i = 0; i < 500; i++) begin
            r_clr  = ($urandom_range(0, 15) == 0);
            r_load = ($urandom_range(0, 7) == 0);
            r_en   = ($urandom_range(0, 3) != 0);
            r_ci   = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 5) == 0) r_up = ~r_up;
            r_d    = 4'($urandom_range(0, 15));
            #1;
            chk("rnd_a_tc", 32'(a_tc), 32'(ref_tc(ma, r_up, 16)));
            chk("rnd_a_co", 32'(a_co), 32'(ref_tc(ma, r_up, 16) && r_en && r_ci));
            chk("rnd_b_tc", 32'(b_tc), 32'(ref_tc(mb, r_up, 10)));
            chk("rnd_b_co", 32'(b_co), 32'(ref_tc(mb, r_up, 10) && r_en && r_ci));
            na = ref_next(ma, r_clr, r_load, int'(r_d), r_en, r_ci, r_up, 16, 0);
            nb = ref_next(mb, r_clr, r_load, int'(r_d), r_en, r_ci, r_up, 10, 3);
            @(posedge clk); #1;
            ma = na; mb = nb;
            chk("rnd_a_q", 32'(a_q), 32'(ma));
            chk("rnd_b_q", 32'(b_q), 32'(mb));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
